makekey_scheduler: RTL and testbench

Sequencer for the Rijndael round-key store: runs one complete key-schedule load of the encrypt (m_Ke) and decrypt (m_Kd) RAMs. It requests 4-word round-key groups from the key-expansion datapath and hands each group to the RAM writer. It issues the writer's start pulse and word offset, then waits for its done strobe. Block size is fixed at BC=4 words, so every group fills exactly one RAM address.

---
 rtl/makekey_scheduler.sv | 150 +++++++++++++++
 tb/tb_makekey_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/makekey_scheduler.sv
// Sequencer for one Rijndael round-key store load: requests 4-word groups from
// the key-expansion datapath and hands each to the RAM writer at offset t.
module makekey_scheduler #(
    parameter int BC = 4
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iStart,
    input  logic [3:0]  iKC,
    output logic        oBusy,
    output logic        oDone,
    output logic        oErr,
    output logic [3:0]  oRound,
    output logic        oGen_req,
    input  logic        iGen_valid,
    input  logic [31:0] iGen_key_1,
    input  logic [31:0] iGen_key_2,
    input  logic [31:0] iGen_key_3,
    input  logic [31:0] iGen_key_4,
    output logic        oWr_start,
    output logic [6:0]  oWr_count,
    output logic [31:0] oKEY_1,
    output logic [31:0] oKEY_2,
    output logic [31:0] oKEY_3,
    output logic [31:0] oKEY_4,
    input  logic        iWr_done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GEN_REQ  = 3'd1,
        WR_START = 3'd2,
        WR_WAIT  = 3'd3,
        DONE     = 3'd4
    } stateT;

    localparam logic [3:0] BC_W = 4'(BC);

    stateT       stateReg, stateNext;
    logic [3:0]  roundReg, roundNext;
    logic [6:0]  totalReg, totalNext;
    logic [6:0]  tReg, tNext;
    logic [6:0]  wrCountReg, wrCountNext;
    logic        genReqReg, genReqNext;
    logic        wrStartReg, wrStartNext;
    logic        doneReg, doneNext;
    logic        errReg, errNext;
    logic        keyLoad;
    logic        kcLegal;
    logic        lastGroup;
    logic [3:0]  roundCalc;
    logic [31:0] genKey [4];
    logic [31:0] keyReg [4];

    assign kcLegal   = (iKC == 4'd4) || (iKC == 4'd6) || (iKC == 4'd8);
    assign roundCalc = ((iKC > BC_W) ? iKC : BC_W) + 4'd6;
    assign lastGroup = ((tReg + 7'd4) == totalReg);

    assign genKey[0] = iGen_key_1;
    assign genKey[1] = iGen_key_2;
    assign genKey[2] = iGen_key_3;
    assign genKey[3] = iGen_key_4;

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:     if (iStart && kcLegal) stateNext = GEN_REQ;
            GEN_REQ:  if (iGen_valid) stateNext = WR_START;
            WR_START: stateNext = WR_WAIT;
            WR_WAIT:  if (iWr_done) stateNext = lastGroup ? DONE : GEN_REQ;
            DONE:     stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    // Strobes are computed from the next state so they appear registered
    // in the same cycle the FSM enters the corresponding state.
    always_comb begin
        genReqNext  = (stateNext == GEN_REQ);
        wrStartNext = (stateNext == WR_START);
        doneNext    = (stateNext == DONE);
        errNext     = (stateReg == IDLE) && iStart && !kcLegal;
        roundNext   = roundReg;
        totalNext   = totalReg;
        tNext       = tReg;
        wrCountNext = wrCountReg;
        keyLoad     = (stateReg == GEN_REQ) && iGen_valid;
        if (stateReg == IDLE && iStart && kcLegal) begin
            roundNext = roundCalc;
            totalNext = {1'b0, roundCalc, 2'b00} + 7'd4;
            tNext     = 7'd0;
        end
        if (stateReg == WR_WAIT && iWr_done && !lastGroup) begin
            tNext = tReg + 7'd4;
        end
        if (stateNext == WR_START) begin
            wrCountNext = tReg;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            stateReg   <= IDLE;
            roundReg   <= '0;
            totalReg   <= '0;
            tReg       <= '0;
            wrCountReg <= '0;
            genReqReg  <= 1'b0;
            wrStartReg <= 1'b0;
            doneReg    <= 1'b0;
            errReg     <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            roundReg   <= roundNext;
            totalReg   <= totalNext;
            tReg       <= tNext;
            wrCountReg <= wrCountNext;
            genReqReg  <= genReqNext;
            wrStartReg <= wrStartNext;
            doneReg    <= doneNext;
            errReg     <= errNext;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gKey
            always_ff @(posedge iClk) begin
                if (iRst) begin
                    keyReg[gi] <= '0;
                end else if (keyLoad) begin
                    keyReg[gi] <= genKey[gi];
                end
            end
        end
    endgenerate

    assign oBusy     = (stateReg != IDLE);
    assign oDone     = doneReg;
    assign oErr      = errReg;
    assign oRound    = roundReg;
    assign oGen_req  = genReqReg;
    assign oWr_start = wrStartReg;
    assign oWr_count = wrCountReg;
    assign oKEY_1    = keyReg[0];
    assign oKEY_2    = keyReg[1];
    assign oKEY_3    = keyReg[2];
    assign oKEY_4    = keyReg[3];

endmodule

// File: tb/tb_makekey_scheduler.sv
// Randomised bench for makekey_scheduler: behavioural generator and writer
// models drive the DUT; expected offsets, keys and strobes come from R=max(KC,4)+6.
module tb_makekey_scheduler;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iStart;
    logic [3:0]  iKC;
    logic        oBusy, oDone, oErr;
    logic [3:0]  oRound;
    logic        oGen_req;
    logic        iGen_valid;
    logic [31:0] iGen_key_1, iGen_key_2, iGen_key_3, iGen_key_4;
    logic        oWr_start;
    logic [6:0]  oWr_count;
    logic [31:0] oKEY_1, oKEY_2, oKEY_3, oKEY_4;
    logic        iWr_done;

    int checkCount = 0;
    int errorCount = 0;
    int lastRound  = 0;

    makekey_scheduler #(.BC(4)) dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iKC(iKC),
        .oBusy(oBusy), .oDone(oDone), .oErr(oErr), .oRound(oRound),
        .oGen_req(oGen_req), .iGen_valid(iGen_valid),
        .iGen_key_1(iGen_key_1), .iGen_key_2(iGen_key_2),
        .iGen_key_3(iGen_key_3), .iGen_key_4(iGen_key_4),
        .oWr_start(oWr_start), .oWr_count(oWr_count),
        .oKEY_1(oKEY_1), .oKEY_2(oKEY_2), .oKEY_3(oKEY_3), .oKEY_4(oKEY_4),
        .iWr_done(iWr_done)
    );

    always #5 iClk = ~iClk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkKeys(input string tag, input logic [31:0] k0, input logic [31:0] k1,
                             input logic [31:0] k2, input logic [31:0] k3);
        checkEq({tag, "_key1"}, oKEY_1, k0);
        checkEq({tag, "_key2"}, oKEY_2, k1);
        checkEq({tag, "_key3"}, oKEY_3, k2);
        checkEq({tag, "_key4"}, oKEY_4, k3);
    endtask

    task automatic checkAllZero(input string tag);
        checkEq({tag, "_busy"},  32'(oBusy), 0);
        checkEq({tag, "_done"},  32'(oDone), 0);
        checkEq({tag, "_err"},   32'(oErr), 0);
        checkEq({tag, "_req"},   32'(oGen_req), 0);
        checkEq({tag, "_wrst"},  32'(oWr_start), 0);
        checkEq({tag, "_round"}, 32'(oRound), 0);
        checkEq({tag, "_count"}, 32'(oWr_count), 0);
        checkKeys(tag, 0, 0, 0, 0);
    endtask

    // One load from iStart to the idle cycle after oDone (or to a mid-load reset).
    task automatic runLoad(input int kc, input int minLat, input int maxLat,
                           input bit noise, input int rstGroup);
        int rounds = ((kc > 4) ? kc : 4) + 6;
        int groups = rounds + 1;
        int grp = 0, cyc = 0, genLeft = 0, wrLeft = 0;
        bit reqDue = 1'b1, inReq = 1'b0, startDue = 1'b0, waiting = 1'b0;
        bit doneDue = 1'b0, finished = 1'b0, afterDone = 1'b0;
        logic [31:0] expKey [4];
        int doneCount = 0;

        @(negedge iClk);
        iStart = 1'b1;
        iKC    = 4'(kc);
        lastRound = rounds;
        while (!finished && cyc < 3000) begin
            @(negedge iClk);
            cyc++;
            iStart = 1'b0;
            iGen_valid = 1'b0;
            iWr_done = 1'b0;
            iRst = 1'b0;

            if (afterDone) begin
                checkEq("idle_busy", 32'(oBusy), 0);
                checkEq("idle_req", 32'(oGen_req), 0);
                checkEq("done_count", doneCount, 1);
                checkEq("group_count", grp, groups);
                finished = 1'b1;
                continue;
            end
            if (reqDue) begin
                checkEq("gen_req", 32'(oGen_req), 1);
                reqDue  = 1'b0;
                inReq   = 1'b1;
                genLeft = $urandom_range(maxLat, minLat);
            end
            if (oWr_start || startDue) begin
                checkEq("wr_start", 32'(oWr_start), 32'(startDue));
                if (oWr_start) begin
                    checkEq("wr_count", 32'(oWr_count), 4 * grp);
                    checkEq("round", 32'(oRound), rounds);
                    checkKeys("start", expKey[0], expKey[1], expKey[2], expKey[3]);
                    checkEq("busy", 32'(oBusy), 1);
                    $display("kc=%0d group %0d wr_count=%0d round=%0d", kc, grp, oWr_count, oRound);
                    waiting = 1'b1;
                    wrLeft  = 4;
                end
                startDue = 1'b0;
            end
            if (oDone || doneDue) begin
                checkEq("done", 32'(oDone), 32'(doneDue));
                if (oDone) doneCount++;
                if (doneDue) begin
                    afterDone = 1'b1;
                    if (noise) begin
                        iStart = 1'b1;
                        iKC    = 4'd8;
                    end
                end
                doneDue = 1'b0;
            end

            if (inReq) begin
                if (genLeft == 0) begin
                    for (int i = 0; i < 4; i++) expKey[i] = $urandom;
                    iGen_valid = 1'b1;
                    {iGen_key_1, iGen_key_2, iGen_key_3, iGen_key_4} =
                        {expKey[0], expKey[1], expKey[2], expKey[3]};
                    startDue = 1'b1;
                    inReq    = 1'b0;
                end else begin
                    genLeft--;
                    if (noise) iWr_done = 1'($urandom_range(1, 0));
                end
            end else if (noise) begin
                iGen_valid = 1'b1;
                {iGen_key_1, iGen_key_2, iGen_key_3, iGen_key_4} =
                    {$urandom, $urandom, $urandom, $urandom};
            end

            if (waiting) begin
                if (grp == rstGroup && wrLeft == 2) begin
                    iRst = 1'b1;
                    @(negedge iClk);
                    iRst = 1'b0;
                    iGen_valid = 1'b0;
                    checkAllZero("reset");
                    $display("reset applied during group %0d", grp);
                    lastRound = 0;
                    return;
                end
                if (wrLeft == 0) begin
                    checkKeys("stable", expKey[0], expKey[1], expKey[2], expKey[3]);
                    iWr_done = 1'b1;
                    waiting  = 1'b0;
                    grp++;
                    if (grp < groups) reqDue = 1'b1;
                    else doneDue = 1'b1;
                end else begin
                    wrLeft--;
                    if (noise && $urandom_range(1, 0) == 1) begin
                        iStart = 1'b1;
                        iKC    = 4'($urandom_range(15, 0));
                    end
                end
            end
        end
        if (!finished) checkEq("timeout", 0, 1);
    endtask

    task automatic runIllegal(input logic [3:0] kc);
        @(negedge iClk);
        iStart = 1'b1;
        iKC    = kc;
        @(negedge iClk);
        iStart = 1'b0;
        checkEq("err_pulse", 32'(oErr), 1);
        checkEq("err_busy", 32'(oBusy), 0);
        checkEq("err_req", 32'(oGen_req), 0);
        checkEq("err_round", 32'(oRound), lastRound);
        @(negedge iClk);
        checkEq("err_clear", 32'(oErr), 0);
        checkEq("err_busy2", 32'(oBusy), 0);
        checkEq("err_req2", 32'(oGen_req), 0);
        $display("illegal kc=%0d rejected", kc);
    endtask

    initial begin
        iRst = 1'b1; iStart = 1'b0; iKC = 4'd0;
        iGen_valid = 1'b0; iWr_done = 1'b0;
        {iGen_key_1, iGen_key_2, iGen_key_3, iGen_key_4} = '0;
        repeat (3) @(negedge iClk);
        iRst = 1'b0;
        checkAllZero("rst");

        runLoad(4, 1, 1, 1'b0, -1);
        runLoad(8, 0, 5, 1'b0, -1);
        runIllegal(4'd5);
        runLoad(6, 0, 3, 1'b0, -1);
        runIllegal(4'($urandom_range(3, 0)));
        runLoad(4, 0, 3, 1'b1, -1);
        runLoad(8, 0, 4, 1'b1, -1);
        runLoad(6, 0, 2, 1'b0, 4);
        runLoad(4, 1, 1, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
